// File: rtl/cube_scan_pkg.sv
// Shared definitions for the cube scan controller.
// Holds the FSM state encoding, the 11-bit raster coordinate type, the
// facelet count, the default parameter values and a small distance helper.
package cube_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  typedef logic [10:0] coord_t;

  localparam int unsigned FACELET_COUNT      = 9;

  localparam int unsigned DEF_STABLE_FRAMES  = 4;
  localparam int unsigned DEF_POS_TOL        = 4;
  localparam int unsigned DEF_FACE_PITCH     = 64;
  localparam int unsigned DEF_TIMEOUT_FRAMES = 60;

  // Absolute difference of two coordinates.
  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a > b) ? coord_t'(a - b) : coord_t'(b - a);
  endfunction

endpackage

// File: rtl/facelet_addr_gen.sv
// Facelet sample-point generator.
// Maps facelet index k (0..8, row = k/3, col = k%3) plus the cube origin to
// the centre of that facelet, FACE_PITCH pixels apart. Sums are formed at
// 12 bits and saturate to 11'h7FF.
// Ports:
//   origin_x, origin_y : locked cube origin
//   idx                : facelet index 0..8
//   sample_x, sample_y : saturated sample point
module facelet_addr_gen
  import cube_scan_pkg::*;
#(
  parameter int unsigned FACE_PITCH = DEF_FACE_PITCH
) (
  input  coord_t     origin_x,
  input  coord_t     origin_y,
  input  logic [3:0] idx,
  output coord_t     sample_x,
  output coord_t     sample_y
);

  localparam logic [11:0] HALF = 12'(FACE_PITCH / 2);

  logic [1:0]  row;
  logic [1:0]  col;
  logic [11:0] sum_x;
  logic [11:0] sum_y;

  always_comb begin
    row   = 2'(idx / 4'd3);
    col   = 2'(idx % 4'd3);
    sum_x = {1'b0, origin_x} + 12'(32'(col) * FACE_PITCH) + HALF;
    sum_y = {1'b0, origin_y} + 12'(32'(row) * FACE_PITCH) + HALF;
    sample_x = sum_x[11] ? 11'h7FF : sum_x[10:0];
    sample_y = sum_y[11] ? 11'h7FF : sum_y[10:0];
  end

endmodule

// File: rtl/cube_scan_ctrl.sv
// Cube scan controller.
// Searches video frames for a stable cube origin (first detected pixel of
// each frame in raster order), locks once the origin has matched within
// POS_TOL for STABLE_FRAMES consecutive frames, then walks the nine facelet
// sample points through a req/ack handshake and pulses oDone.
// Optional feature macro: CUBE_SCAN_TIMEOUT_EN adds parameter TIMEOUT_FRAMES
// and output oTimeout, abandoning the search after that many frame starts.
// Ports:
//   iCLK, iRST_N              : clock, synchronous active-low reset
//   iX_Cont, iY_Cont, iDVAL   : raster position / pixel valid
//   iDetected, iFrame_Start   : detector flag, frame-start pulse
//   iStart, iAbort            : arm / cancel a scan
//   oCubeX, oCubeY, oLocked   : locked origin
//   oSample_Req, iSample_Ack  : facelet sample handshake
//   oSample_X, oSample_Y      : requested sample point
//   oFacelet_Idx              : facelet index 0..8
//   oBusy, oDone              : not idle / scan-complete pulse
//   oTimeout                  : search timeout pulse (macro only)
module cube_scan_ctrl
  import cube_scan_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES  = DEF_STABLE_FRAMES,
  parameter int unsigned POS_TOL        = DEF_POS_TOL,
  parameter int unsigned FACE_PITCH     = DEF_FACE_PITCH
`ifdef CUBE_SCAN_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
`endif
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  input  logic        iDVAL,
  input  logic        iDetected,
  input  logic        iFrame_Start,
  input  logic        iStart,
  input  logic        iAbort,
  output logic [10:0] oCubeX,
  output logic [10:0] oCubeY,
  output logic        oLocked,
  output logic        oSample_Req,
  input  logic        iSample_Ack,
  output logic [10:0] oSample_X,
  output logic [10:0] oSample_Y,
  output logic [3:0]  oFacelet_Idx,
  output logic        oBusy,
  output logic        oDone
`ifdef CUBE_SCAN_TIMEOUT_EN
  ,
  output logic        oTimeout
`endif
);

  localparam int unsigned CW = $clog2(STABLE_FRAMES + 1);

  state_t     state;
  state_t     next;

  coord_t     cand_x, cand_y;
  coord_t     prev_x, prev_y;
  coord_t     cube_x, cube_y;
  coord_t     gen_x, gen_y;
  logic       cand_valid;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] new_cnt;
  logic [3:0] k;
  logic       req;
  logic       pend_inc;
  logic       locked;

  logic       hit;
  logic       fs_eval;
  logic       match;
  logic       lock_now;
  logic       last_ack;

`ifdef CUBE_SCAN_TIMEOUT_EN
  localparam int unsigned FW = $clog2(TIMEOUT_FRAMES + 1);
  logic [FW-1:0] frame_cnt;
  logic          timeout;
  logic          timeout_now;
`endif

  // Frame evaluation uses the candidate of the frame just ended; a hit in
  // the same cycle as iFrame_Start is then latched as the new frame's
  // candidate.
  always_comb begin
    hit      = iDVAL & iDetected;
    fs_eval  = (state == ST_SEARCH) && iFrame_Start;
    match    = (abs_diff(cand_x, prev_x) <= coord_t'(POS_TOL)) &&
               (abs_diff(cand_y, prev_y) <= coord_t'(POS_TOL));
    new_cnt  = cand_valid ? (match ? stable_cnt + 1'b1 : CW'(1)) : '0;
    lock_now = fs_eval && (new_cnt == CW'(STABLE_FRAMES));
    last_ack = req && iSample_Ack && (k == 4'(FACELET_COUNT - 1));
`ifdef CUBE_SCAN_TIMEOUT_EN
    timeout_now = fs_eval && !lock_now && (frame_cnt == FW'(TIMEOUT_FRAMES - 1));
`endif
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) state <= ST_IDLE;
    else         state <= next;
  end

  always_comb begin
    next  = state;
    oBusy = (state != ST_IDLE);
    oDone = (state == ST_DONE);
    case (state)
      ST_IDLE:   if (iStart) next = ST_SEARCH;
      ST_SEARCH: begin
        if (lock_now) next = ST_SAMPLE;
`ifdef CUBE_SCAN_TIMEOUT_EN
        else if (timeout_now) next = ST_IDLE;
`endif
      end
      ST_SAMPLE: if (last_ack) next = ST_DONE;
      ST_DONE:   next = ST_IDLE;
      default:   next = ST_IDLE;
    endcase
    if (iAbort) next = ST_IDLE;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      cand_valid <= 1'b0;
      cand_x     <= '0;
      cand_y     <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      cube_x     <= '0;
      cube_y     <= '0;
      stable_cnt <= '0;
      k          <= '0;
      req        <= 1'b0;
      pend_inc   <= 1'b0;
      locked     <= 1'b0;
`ifdef CUBE_SCAN_TIMEOUT_EN
      frame_cnt  <= '0;
      timeout    <= 1'b0;
`endif
    end else if (iAbort) begin
      req      <= 1'b0;
      pend_inc <= 1'b0;
      locked   <= 1'b0;
`ifdef CUBE_SCAN_TIMEOUT_EN
      timeout  <= 1'b0;
`endif
    end else begin
`ifdef CUBE_SCAN_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            cand_valid <= 1'b0;
            cand_x     <= '0;
            cand_y     <= '0;
            prev_x     <= '0;
            prev_y     <= '0;
            cube_x     <= '0;
            cube_y     <= '0;
            stable_cnt <= '0;
            k          <= '0;
            req        <= 1'b0;
            pend_inc   <= 1'b0;
            locked     <= 1'b0;
`ifdef CUBE_SCAN_TIMEOUT_EN
            frame_cnt  <= '0;
`endif
          end
        end
        ST_SEARCH: begin
          if (iFrame_Start) begin
            stable_cnt <= new_cnt;
            prev_x     <= cand_x;
            prev_y     <= cand_y;
            cand_valid <= hit;
            cand_x     <= hit ? iX_Cont : '0;
            cand_y     <= hit ? iY_Cont : '0;
`ifdef CUBE_SCAN_TIMEOUT_EN
            frame_cnt  <= frame_cnt + 1'b1;
            if (timeout_now) timeout <= 1'b1;
`endif
            if (lock_now) begin
              cube_x   <= cand_x;
              cube_y   <= cand_y;
              locked   <= 1'b1;
              k        <= '0;
              req      <= 1'b0;
              pend_inc <= 1'b0;
            end
          end else if (hit && !cand_valid) begin
            cand_valid <= 1'b1;
            cand_x     <= iX_Cont;
            cand_y     <= iY_Cont;
          end
        end
        ST_SAMPLE: begin
          // req low covers both the entry cycle and the one-cycle gap after
          // an ack; pend_inc distinguishes the gap so k advances only there.
          if (req) begin
            if (iSample_Ack) begin
              req      <= 1'b0;
              pend_inc <= !last_ack;
            end
          end else begin
            req <= 1'b1;
            if (pend_inc) begin
              k        <= k + 4'd1;
              pend_inc <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  facelet_addr_gen #(
    .FACE_PITCH(FACE_PITCH)
  ) u_addr_gen (
    .origin_x(cube_x),
    .origin_y(cube_y),
    .idx     (k),
    .sample_x(gen_x),
    .sample_y(gen_y)
  );

  always_comb begin
    oCubeX       = cube_x;
    oCubeY       = cube_y;
    oLocked      = locked;
    oSample_Req  = req;
    oFacelet_Idx = k;
    oSample_X    = (state == ST_SAMPLE) ? gen_x : '0;
    oSample_Y    = (state == ST_SAMPLE) ? gen_y : '0;
`ifdef CUBE_SCAN_TIMEOUT_EN
    oTimeout     = timeout;
`endif
  end

endmodule

// File: tb/tb_cube_scan_ctrl.sv
// Self-checking bench for cube_scan_ctrl (default parameters; with
// CUBE_SCAN_TIMEOUT_EN defined, TIMEOUT_FRAMES is overridden to 8).
module tb_cube_scan_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [10:0] iX_Cont = '0, iY_Cont = '0;
  logic        iDVAL = 1'b0, iDetected = 1'b0, iFrame_Start = 1'b0;
  logic        iStart = 1'b0, iAbort = 1'b0, iSample_Ack = 1'b0;
  logic [10:0] oCubeX, oCubeY, oSample_X, oSample_Y;
  logic        oLocked, oSample_Req, oBusy, oDone;
  logic [3:0]  oFacelet_Idx;
`ifdef CUBE_SCAN_TIMEOUT_EN
  logic        oTimeout;
  int          timeout_pulses = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_pulses = 0;

  typedef struct {
    logic [3:0]  idx;
    logic [10:0] x;
    logic [10:0] y;
  } samp_t;
  samp_t exp_q[$];

  cube_scan_ctrl #(
    .STABLE_FRAMES(4),
    .POS_TOL(4),
    .FACE_PITCH(64)
`ifdef CUBE_SCAN_TIMEOUT_EN
    ,
    .TIMEOUT_FRAMES(8)
`endif
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .iDVAL(iDVAL), .iDetected(iDetected), .iFrame_Start(iFrame_Start),
    .iStart(iStart), .iAbort(iAbort),
    .oCubeX(oCubeX), .oCubeY(oCubeY), .oLocked(oLocked),
    .oSample_Req(oSample_Req), .iSample_Ack(iSample_Ack),
    .oSample_X(oSample_X), .oSample_Y(oSample_Y),
    .oFacelet_Idx(oFacelet_Idx),
    .oBusy(oBusy), .oDone(oDone)
`ifdef CUBE_SCAN_TIMEOUT_EN
    ,
    .oTimeout(oTimeout)
`endif
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    if (oDone === 1'b1) done_pulses++;
`ifdef CUBE_SCAN_TIMEOUT_EN
    if (oTimeout === 1'b1) timeout_pulses++;
`endif
  end

  function automatic logic [10:0] sat(input int v);
    return (v > 2047) ? 11'h7FF : 11'(v);
  endfunction

  task automatic push_samples(input int ox, input int oy);
    samp_t s;
    for (int k = 0; k < 9; k++) begin
      s.idx = 4'(k);
      s.x   = sat(ox + (k % 3) * 64 + 32);
      s.y   = sat(oy + (k / 3) * 64 + 32);
      exp_q.push_back(s);
    end
  endtask

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle_inputs();
    iX_Cont = '0; iY_Cont = '0; iDVAL = 1'b0; iDetected = 1'b0;
    iFrame_Start = 1'b0; iStart = 1'b0; iAbort = 1'b0; iSample_Ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    iRST_N = 1'b0;
    cyc(); cyc();
    iRST_N = 1'b1;
    cyc();
  endtask

  task automatic arm();
    iStart = 1'b1; cyc(); iStart = 1'b0;
  endtask

  task automatic pixel(input int x, input int y, input logic det, input logic fs);
    iX_Cont = 11'(x); iY_Cont = 11'(y); iDVAL = 1'b1; iDetected = det; iFrame_Start = fs;
    cyc();
    iDVAL = 1'b0; iDetected = 1'b0; iFrame_Start = 1'b0;
  endtask

  // First hit at (x,y); a later, distant hit in the same frame must be ignored.
  task automatic frame(input int x, input int y);
    pixel(5, 5, 1'b0, 1'b0);
    pixel(x, y, 1'b1, 1'b0);
    pixel(x + 20, y + 3, 1'b1, 1'b0);
    pixel(x + 21, y + 3, 1'b0, 1'b0);
  endtask

  task automatic fstart();
    iFrame_Start = 1'b1; cyc(); iFrame_Start = 1'b0;
  endtask

  task automatic lock_at(input int x, input int y);
    arm();
    repeat (4) begin
      frame(x, y);
      fstart();
    end
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    iStart = 1'b1; iDVAL = 1'b1; iDetected = 1'b1; iFrame_Start = 1'b1; iSample_Ack = 1'b1;
    iX_Cont = 11'd300; iY_Cont = 11'd200;
    cyc(); cyc();
    n_checks++;
    if ({oBusy, oDone, oLocked, oSample_Req} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {oBusy, oDone, oLocked, oSample_Req});
    end
    n_checks++;
    if ({oCubeX, oCubeY, oSample_X, oSample_Y, oFacelet_Idx} !== '0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", {oCubeX, oCubeY, oSample_X, oSample_Y, oFacelet_Idx});
    end
`ifdef CUBE_SCAN_TIMEOUT_EN
    n_checks++;
    if (oTimeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", oTimeout); end
`endif
    idle_inputs();
    iRST_N = 1'b1;
    cyc();
    n_checks++;
    if (oBusy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b want 0", oBusy); end
  endtask

  task automatic test_lock_basic();
    do_reset();
    arm();
    n_checks++;
    if (oBusy !== 1'b1) begin n_fail++; $display("FAIL arm_busy got %b want 1", oBusy); end
    for (int f = 0; f < 4; f++) begin
      frame(100, 80);
      fstart();
      n_checks++;
      if (oLocked !== (f == 3)) begin
        n_fail++; $display("FAIL lock_basic_f%0d got %b want %b", f, oLocked, (f == 3));
      end
    end
    n_checks++;
    if (oCubeX !== 11'd100 || oCubeY !== 11'd80) begin
      n_fail++; $display("FAIL lock_basic_origin got (%0d,%0d) want (100,80)", oCubeX, oCubeY);
    end
  endtask

  task automatic test_stability();
    int xs[6] = '{100, 103, 110, 110, 111, 112};
    int ys[6] = '{80, 82, 80, 81, 80, 79};
    int ec[6] = '{1, 2, 1, 2, 3, 4};
    do_reset();
    arm();
    for (int f = 0; f < 6; f++) begin
      frame(xs[f], ys[f]);
      fstart();
      n_checks++;
      if (oLocked !== (ec[f] == 4)) begin
        n_fail++; $display("FAIL stability_f%0d locked got %b want %b", f, oLocked, (ec[f] == 4));
      end
    end
    n_checks++;
    if (oCubeX !== 11'd112 || oCubeY !== 11'd79) begin
      n_fail++; $display("FAIL stability_origin got (%0d,%0d) want (112,79)", oCubeX, oCubeY);
    end
  endtask

  task automatic test_start_ignored();
    do_reset();
    arm();
    frame(100, 80); fstart();
    frame(100, 80); fstart();
    arm();
    frame(100, 80); fstart();
    n_checks++;
    if (oLocked !== 1'b0) begin n_fail++; $display("FAIL start_ignored_early got %b want 0", oLocked); end
    frame(100, 80); fstart();
    n_checks++;
    if (oLocked !== 1'b1) begin n_fail++; $display("FAIL start_ignored_lock got %b want 1", oLocked); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    arm();
    pixel(5, 5, 1'b0, 1'b0);
    pixel(50, 60, 1'b1, 1'b0);
    repeat (3) begin
      pixel(50, 60, 1'b1, 1'b1);
      pixel(300, 300, 1'b1, 1'b0);
      pixel(6, 6, 1'b0, 1'b0);
    end
    fstart();
    n_checks++;
    if (oLocked !== 1'b1 || oCubeX !== 11'd50 || oCubeY !== 11'd60) begin
      n_fail++; $display("FAIL same_cycle got locked=%b (%0d,%0d) want 1 (50,60)", oLocked, oCubeX, oCubeY);
    end
  endtask

  task automatic test_sampling();
    samp_t e;
    int d0;
    int w;
    do_reset();
    lock_at(100, 80);
    push_samples(100, 80);
    d0 = done_pulses;
    n_checks++;
    if (oSample_Req !== 1'b0) begin n_fail++; $display("FAIL req_entry got %b want 0", oSample_Req); end
    iSample_Ack = 1'b1;
    cyc();
    iSample_Ack = 1'b0;
    n_checks++;
    if (oSample_Req !== 1'b1 || oFacelet_Idx !== 4'd0) begin
      n_fail++; $display("FAIL req_rise got req=%b idx=%0d want 1 0", oSample_Req, oFacelet_Idx);
    end
    for (int r = 0; r < 9; r++) begin
      w = 0;
      while (oSample_Req !== 1'b1 && w < 10) begin cyc(); w++; end
      n_checks++;
      if (oSample_Req !== 1'b1) begin n_fail++; $display("FAIL req_wait_k%0d got 0 want 1", r); end
      e = exp_q.pop_front();
      n_checks++;
      if (oFacelet_Idx !== e.idx || oSample_X !== e.x || oSample_Y !== e.y) begin
        n_fail++; $display("FAIL sample_k%0d got idx=%0d (%0d,%0d) want idx=%0d (%0d,%0d)",
                           r, oFacelet_Idx, oSample_X, oSample_Y, e.idx, e.x, e.y);
      end
      repeat (3) cyc();
      n_checks++;
      if (oSample_Req !== 1'b1 || oFacelet_Idx !== e.idx || oSample_X !== e.x || oSample_Y !== e.y) begin
        n_fail++; $display("FAIL hold_k%0d got req=%b idx=%0d (%0d,%0d) want 1 idx=%0d (%0d,%0d)",
                           r, oSample_Req, oFacelet_Idx, oSample_X, oSample_Y, e.idx, e.x, e.y);
      end
      iSample_Ack = 1'b1;
      cyc();
      iSample_Ack = 1'b0;
      n_checks++;
      if (oSample_Req !== 1'b0) begin n_fail++; $display("FAIL req_drop_k%0d got %b want 0", r, oSample_Req); end
      if (r < 8) begin
        cyc();
        n_checks++;
        if (oSample_Req !== 1'b1 || oFacelet_Idx !== 4'(r + 1)) begin
          n_fail++; $display("FAIL req_reassert_k%0d got req=%b idx=%0d want 1 %0d", r, oSample_Req, oFacelet_Idx, r + 1);
        end
      end
    end
    n_checks++;
    if (oDone !== 1'b1) begin n_fail++; $display("FAIL done_pulse got %b want 1", oDone); end
    cyc();
    n_checks++;
    if (oDone !== 1'b0 || oBusy !== 1'b0) begin
      n_fail++; $display("FAIL done_end got done=%b busy=%b want 0 0", oDone, oBusy);
    end
    n_checks++;
    if (oLocked !== 1'b1 || oCubeX !== 11'd100 || oCubeY !== 11'd80) begin
      n_fail++; $display("FAIL idle_hold got locked=%b (%0d,%0d) want 1 (100,80)", oLocked, oCubeX, oCubeY);
    end
    repeat (3) cyc();
    n_checks++;
    if (done_pulses - d0 !== 1) begin n_fail++; $display("FAIL done_count got %0d want 1", done_pulses - d0); end
  endtask

  task automatic test_saturation();
    int w;
    do_reset();
    lock_at(2000, 2000);
    for (int k = 0; k < 9; k++) begin
      w = 0;
      while (oSample_Req !== 1'b1 && w < 10) begin cyc(); w++; end
      n_checks++;
      if (oFacelet_Idx !== 4'(k) || oSample_X !== sat(2000 + (k % 3) * 64 + 32) ||
          oSample_Y !== sat(2000 + (k / 3) * 64 + 32)) begin
        n_fail++; $display("FAIL sat_k%0d got idx=%0d (%0d,%0d) want idx=%0d (%0d,%0d)", k, oFacelet_Idx,
                           oSample_X, oSample_Y, k, sat(2000 + (k % 3) * 64 + 32), sat(2000 + (k / 3) * 64 + 32));
      end
      iSample_Ack = 1'b1; cyc(); iSample_Ack = 1'b0;
    end
    cyc();
  endtask

  task automatic test_abort();
    int d0;
    do_reset();
    lock_at(100, 80);
    d0 = done_pulses;
    for (int c = 0; c < 100 && !(oSample_Req === 1'b1 && oFacelet_Idx == 4'd5); c++) begin
      if (oSample_Req === 1'b1) begin
        iSample_Ack = 1'b1; cyc(); iSample_Ack = 1'b0;
      end else begin
        cyc();
      end
    end
    n_checks++;
    if (oSample_Req !== 1'b1 || oFacelet_Idx !== 4'd5) begin
      n_fail++; $display("FAIL abort_reach_k5 got req=%b idx=%0d want 1 5", oSample_Req, oFacelet_Idx);
    end
    iAbort = 1'b1; iSample_Ack = 1'b1; iStart = 1'b1; iFrame_Start = 1'b1;
    cyc();
    idle_inputs();
    n_checks++;
    if ({oBusy, oSample_Req, oLocked} !== 3'b000) begin
      n_fail++; $display("FAIL abort_state got busy/req/locked=%b want 000", {oBusy, oSample_Req, oLocked});
    end
    repeat (5) cyc();
    n_checks++;
    if (done_pulses !== d0 || oBusy !== 1'b0) begin
      n_fail++; $display("FAIL abort_nodone got done=%0d busy=%b want 0 0", done_pulses - d0, oBusy);
    end
  endtask

  task automatic test_reset_midscan();
    int d0;
    do_reset();
    lock_at(100, 80);
    repeat (2) cyc();
    d0 = done_pulses;
    iRST_N = 1'b0;
    cyc();
    iRST_N = 1'b1;
    n_checks++;
    if ({oBusy, oLocked, oSample_Req, oCubeX, oCubeY} !== '0) begin
      n_fail++; $display("FAIL midscan_reset got busy=%b locked=%b req=%b (%0d,%0d) want all 0",
                         oBusy, oLocked, oSample_Req, oCubeX, oCubeY);
    end
    iSample_Ack = 1'b1;
    repeat (12) cyc();
    iSample_Ack = 1'b0;
    n_checks++;
    if (done_pulses !== d0) begin n_fail++; $display("FAIL midscan_nodone got %0d want 0", done_pulses - d0); end
  endtask

  task automatic test_timeout();
    do_reset();
    arm();
`ifdef CUBE_SCAN_TIMEOUT_EN
    begin
      int t0;
      t0 = timeout_pulses;
      for (int f = 1; f <= 8; f++) begin
        pixel(5, 5, 1'b0, 1'b0);
        fstart();
        n_checks++;
        if (oTimeout !== (f == 8) || oBusy !== (f != 8)) begin
          n_fail++; $display("FAIL timeout_f%0d got to=%b busy=%b want %b %b", f, oTimeout, oBusy, (f == 8), (f != 8));
        end
      end
      repeat (3) cyc();
      n_checks++;
      if (timeout_pulses - t0 !== 1 || oBusy !== 1'b0) begin
        n_fail++; $display("FAIL timeout_once got pulses=%0d busy=%b want 1 0", timeout_pulses - t0, oBusy);
      end
    end
`else
    repeat (12) begin
      pixel(5, 5, 1'b0, 1'b0);
      fstart();
    end
    n_checks++;
    if (oBusy !== 1'b1 || oLocked !== 1'b0) begin
      n_fail++; $display("FAIL no_timeout got busy=%b locked=%b want 1 0", oBusy, oLocked);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_stability();
    test_start_ignored();
    test_same_cycle();
    test_sampling();
    test_saturation();
    test_abort();
    test_reset_midscan();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cube_scan_ctrl.md
CUBE_SCAN_CTRL -- requirements
Module: cube_scan_ctrl

Interface
REQ-001 Parameter STABLE_FRAMES, default 4: consecutive frames with a matching cube origin required to lock.
REQ-002 Parameter POS_TOL, default 4: maximum per-axis difference, in pixels, for two frame origins to match.
REQ-003 Parameter FACE_PITCH, default 64: facelet spacing in pixels.
REQ-004 Parameter TIMEOUT_FRAMES, default 60: maximum number of search frames allowed (CUBE_SCAN_TIMEOUT_EN only).
REQ-005 iCLK, input, 1: pixel clock; the only clock in the block.
REQ-006 iRST_N, input, 1: reset, synchronous and active-low.
REQ-007 iX_Cont and iY_Cont, input, 11 each: raster coordinates of the current pixel.
REQ-008 iDVAL, input, 1: the current pixel is valid.
REQ-009 iDetected, input, 1: the per-pixel cube detector flags the current pixel.
REQ-010 iFrame_Start, input, 1: one-cycle pulse before the first pixel of each frame.
REQ-011 iStart and iAbort, input, 1 each: arm a scan; cancel the scan.
REQ-012 oCubeX and oCubeY, output, 11 each: locked cube origin.
REQ-013 oLocked, output, 1: the cube origin is locked.
REQ-014 oSample_Req, output, 1; iSample_Ack, input, 1: facelet sample handshake.
REQ-015 oSample_X, oSample_Y (output, 11 each) and oFacelet_Idx (output, 4): requested sample point and facelet index 0..8.
REQ-016 oBusy (output, 1): state is not IDLE. oDone (output, 1): one-cycle pulse when a scan completes.

Function
REQ-017 The FSM SHALL have the states IDLE, SEARCH, SAMPLE and DONE.
REQ-018 IDLE SHALL go to SEARCH on iStart, clearing the candidate, the previous origin and stable_cnt.
REQ-019 SEARCH SHALL latch the coordinates of the first cycle in a frame with iDVAL and iDetected both high (first in raster order); later hits in that frame SHALL be ignored.
REQ-020 On iFrame_Start in SEARCH, if a candidate exists, stable_cnt SHALL increment when both |dx| and |dy| are <= POS_TOL against the previous origin, and SHALL otherwise be set to 1.
REQ-021 On iFrame_Start in SEARCH, if no candidate exists, stable_cnt SHALL be set to 0.
REQ-022 On every iFrame_Start in SEARCH, the candidate SHALL become the previous origin and the candidate SHALL be cleared.
REQ-023 When stable_cnt reaches STABLE_FRAMES, the block SHALL load oCubeX/oCubeY with the latest origin, raise oLocked and enter SAMPLE on the next cycle.
REQ-024 In SAMPLE, oFacelet_Idx SHALL equal k, with row = k/3 and col = k%3.
REQ-025 oSample_X SHALL equal oCubeX + col*FACE_PITCH + FACE_PITCH/2, and oSample_Y SHALL equal oCubeY + row*FACE_PITCH + FACE_PITCH/2, each computed at 12 bits and saturated to 11'h7FF.
REQ-026 oSample_Req SHALL rise one cycle after SAMPLE is entered and SHALL stay high, with stable address outputs, until iSample_Ack is sampled high.
REQ-027 On iSample_Ack, oSample_Req SHALL drop for exactly one cycle, then k SHALL increment and the request SHALL reassert.
REQ-028 iSample_Ack SHALL be ignored while oSample_Req is low.
REQ-029 The ack for k = 8 SHALL move the FSM to DONE; DONE SHALL pulse oDone for one cycle and return to IDLE.
REQ-030 oLocked and oCubeX/oCubeY SHALL hold in IDLE until the next iStart.
REQ-031 iAbort SHALL force IDLE on the next cycle from any state, clearing oSample_Req and oLocked, and SHALL take priority over iStart, iSample_Ack and iFrame_Start.
REQ-032 iStart SHALL be ignored outside IDLE.
REQ-033 If iFrame_Start and a detected pixel occur in the same cycle, the frame evaluation SHALL run first and the pixel SHALL count toward the new frame.

Reset
REQ-034 While iRST_N is low at a rising edge of iCLK, state SHALL become IDLE and every output SHALL become 0.
REQ-035 On reset, every internal counter and the candidate/previous-origin registers SHALL be cleared.
REQ-036 A reset taken mid-scan SHALL abandon the scan with no oDone pulse.

Configuration
REQ-037 With CUBE_SCAN_TIMEOUT_EN defined, the block SHALL count iFrame_Start pulses in SEARCH.
REQ-038 With CUBE_SCAN_TIMEOUT_EN defined, reaching TIMEOUT_FRAMES without a lock SHALL pulse output oTimeout for one cycle and return the FSM to IDLE.
REQ-039 Without CUBE_SCAN_TIMEOUT_EN, oTimeout and the frame counter SHALL be absent and SEARCH SHALL wait indefinitely.

Structure
REQ-040 A shared package cube_scan_pkg SHALL hold the state enum, the coordinate typedef (11 bits), the facelet count constant 9 and the default parameter values.
REQ-041 A sub-module facelet_addr_gen SHALL compute oSample_X/oSample_Y from origin, k and FACE_PITCH, including saturation.

Verification
REQ-042 Scenario: iStart, then 4 frames each with first hit at (100,80) -> oLocked rises after the 4th iFrame_Start, with oCubeX=100 and oCubeY=80.
REQ-043 Scenario: frame hits at (100,80),(103,82),(110,80),(110,81),(111,80),(112,79) -> stable_cnt runs 1,2,1,2,3,4 and the lock origin is (112,79).
REQ-044 Scenario: after lock at (100,80), ack each request after 3 cycles -> 9 requests, k=0 at (132,112), k=4 at (196,176), k=8 at (260,240), then one oDone pulse.
REQ-045 Scenario: lock at (2000,2000) -> k=8 sample point saturates to (2047,2047).
REQ-046 Scenario: iAbort during k=5 with iSample_Ack high in the same cycle -> IDLE next cycle, oSample_Req=0, oLocked=0, no oDone.
REQ-047 Scenario: CUBE_SCAN_TIMEOUT_EN defined, TIMEOUT_FRAMES=8, no hits for 8 frames -> oTimeout pulses once and the FSM returns to IDLE.
